sram_port_arbiter: RTL and testbench

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/sram_port_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - SRAM port arbiter with clear sweep for builder and peak-finder requesters
// Optional build macro: SRAM_ARB_RR_EN (round-robin tie-break between builder and peak finder)
module sram_port_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 12,
  parameter int CLR_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              res,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  input  logic              b_req,
  output logic              b_gnt,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_waddr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic              b_re,
  input  logic [ADDR_W-1:0] b_raddr,
  output logic              b_rvalid,
  input  logic              p_req,
  output logic              p_gnt,
  input  logic              p_re,
  input  logic [ADDR_W-1:0] p_raddr,
  output logic              p_rvalid,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] raddr,
  output logic              wEnable,
  output logic              rEnable,
  output logic              writeFlag,
  output logic              readFlag,
  output logic [DATA_W-1:0] newCounts,
  input  logic [DATA_W-1:0] counts,
  output logic [DATA_W-1:0] rd_data
);

  typedef enum logic [1:0] {IDLE, CLEAR, GNT_B, GNT_P} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CLR_DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                pend_q, pend_d;
  logic                b_gnt_q, p_gnt_q, clr_done_q;
  logic                b_rd_q, p_rd_q, b_rvalid_q, p_rvalid_q;
  logic [ADDR_W-1:0]   waddr_q, waddr_d, raddr_q, raddr_d;
  logic [DATA_W-1:0]   newc_q, newc_d;
  logic                wen_q, wen_d, ren_q, ren_d, wflag_q, wflag_d, rflag_q, rflag_d;
  logic                b_acc, p_acc;

`ifdef SRAM_ARB_RR_EN
  logic                last_p_q, last_p_d;
`endif

  // An owner's strobes only count while it holds the grant and still requests.
  assign b_acc = b_gnt_q & b_req;
  assign p_acc = p_gnt_q & p_req;

  // Next-state: clear beats builder beats peak finder; grants are non-preemptive.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
`ifdef SRAM_ARB_RR_EN
    last_p_d = last_p_q;
`endif
    case (state_q)
      IDLE: begin
        pend_d = 1'b0;
        cnt_d  = '0;
        if (clr_req || pend_q) begin
          state_d = CLEAR;
        end else if (b_req && p_req) begin
`ifdef SRAM_ARB_RR_EN
          state_d  = last_p_q ? GNT_B : GNT_P;
          last_p_d = ~last_p_q;
`else
          state_d = GNT_B;
`endif
        end else if (b_req) begin
          state_d = GNT_B;
`ifdef SRAM_ARB_RR_EN
          last_p_d = 1'b0;
`endif
        end else if (p_req) begin
          state_d = GNT_P;
`ifdef SRAM_ARB_RR_EN
          last_p_d = 1'b1;
`endif
        end
      end
      CLEAR: begin
        if (cnt_q == LAST_ADDR) state_d = IDLE;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      GNT_B: begin
        if (clr_req) pend_d  = 1'b1;
        if (!b_req)  state_d = IDLE;
      end
      GNT_P: begin
        if (clr_req) pend_d  = 1'b1;
        if (!p_req)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // SRAM port values for the next cycle: clear sweep, else the owner's strobes, else idle levels.
  always_comb begin
    waddr_d = waddr_q;
    raddr_d = raddr_q;
    newc_d  = newc_q;
    wen_d   = 1'b0;
    ren_d   = 1'b1;
    wflag_d = 1'b0;
    rflag_d = 1'b0;
    if (state_d == CLEAR) begin
      waddr_d = cnt_d;
      newc_d  = '0;
      wen_d   = 1'b1;
      wflag_d = 1'b1;
    end else if (b_acc) begin
      if (b_we) begin
        waddr_d = b_waddr;
        newc_d  = b_wdata;
        wen_d   = 1'b1;
        wflag_d = 1'b1;
      end
      if (b_re) begin
        raddr_d = b_raddr;
        ren_d   = 1'b0;
        rflag_d = 1'b1;
      end
    end else if (p_acc && p_re) begin
      raddr_d = p_raddr;
      ren_d   = 1'b0;
      rflag_d = 1'b1;
    end
  end

  // State, grant, read-valid pipeline and SRAM port registers.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      b_gnt_q    <= 1'b0;
      p_gnt_q    <= 1'b0;
      clr_done_q <= 1'b0;
      b_rd_q     <= 1'b0;
      p_rd_q     <= 1'b0;
      b_rvalid_q <= 1'b0;
      p_rvalid_q <= 1'b0;
      waddr_q    <= '0;
      raddr_q    <= '0;
      newc_q     <= '0;
      wen_q      <= 1'b0;
      ren_q      <= 1'b1;
      wflag_q    <= 1'b0;
      rflag_q    <= 1'b0;
`ifdef SRAM_ARB_RR_EN
      last_p_q   <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      b_gnt_q    <= (state_d == GNT_B);
      p_gnt_q    <= (state_d == GNT_P);
      clr_done_q <= (state_q == CLEAR) && (state_d == IDLE);
      b_rd_q     <= b_acc & b_re;
      p_rd_q     <= p_acc & p_re;
      b_rvalid_q <= b_rd_q;
      p_rvalid_q <= p_rd_q;
      waddr_q    <= waddr_d;
      raddr_q    <= raddr_d;
      newc_q     <= newc_d;
      wen_q      <= wen_d;
      ren_q      <= ren_d;
      wflag_q    <= wflag_d;
      rflag_q    <= rflag_d;
`ifdef SRAM_ARB_RR_EN
      last_p_q   <= last_p_d;
`endif
    end
  end

  assign clr_busy  = (state_q == CLEAR);
  assign clr_done  = clr_done_q;
  assign b_gnt     = b_gnt_q;
  assign p_gnt     = p_gnt_q;
  assign b_rvalid  = b_rvalid_q;
  assign p_rvalid  = p_rvalid_q;
  assign waddr     = waddr_q;
  assign raddr     = raddr_q;
  assign newCounts = newc_q;
  assign wEnable   = wen_q;
  assign rEnable   = ren_q;
  assign writeFlag = wflag_q;
  assign readFlag  = rflag_q;
  assign rd_data   = counts;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - self-checking bench for sram_port_arbiter
module tb_sram_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 12;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic res, clr_req, clr_busy, clr_done;
  logic b_req, b_gnt, b_we, b_re, b_rvalid;
  logic [AW-1:0] b_waddr, b_raddr;
  logic [DW-1:0] b_wdata;
  logic p_req, p_gnt, p_re, p_rvalid;
  logic [AW-1:0] p_raddr, waddr, raddr;
  logic wEnable, rEnable, writeFlag, readFlag;
  logic [DW-1:0] newCounts, counts, rd_data;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [31:0] wr_q[$];
  logic [31:0] rd_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CLR_DEPTH(DEPTH)) dut (
    .clk(clk), .res(res), .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
    .b_req(b_req), .b_gnt(b_gnt), .b_we(b_we), .b_waddr(b_waddr), .b_wdata(b_wdata),
    .b_re(b_re), .b_raddr(b_raddr), .b_rvalid(b_rvalid),
    .p_req(p_req), .p_gnt(p_gnt), .p_re(p_re), .p_raddr(p_raddr), .p_rvalid(p_rvalid),
    .waddr(waddr), .raddr(raddr), .wEnable(wEnable), .rEnable(rEnable),
    .writeFlag(writeFlag), .readFlag(readFlag), .newCounts(newCounts), .counts(counts),
    .rd_data(rd_data)
  );

  // SRAM model: port A write, port B registered read (rEnable low = read)
  always @(posedge clk) begin
    if (writeFlag && wEnable) mem[waddr] <= newCounts;
    if (readFlag && !rEnable) counts <= mem[raddr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] wr_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {6'b0, a, 4'b0, d};
  endfunction

  function automatic logic [31:0] rd_word(input logic p, input logic b, input logic [DW-1:0] d);
    return {14'b0, p, b, 4'b0, d};
  endfunction

  // Scoreboard: requester writes and read returns are popped as the DUT produces them
  always @(negedge clk) begin
    if (!res) begin
      if (wEnable && writeFlag && !clr_busy)
        check("sb_write", wr_word(waddr, newCounts),
              (wr_q.size() != 0) ? wr_q.pop_front() : 32'hFFFFFFFF);
      if (b_rvalid || p_rvalid)
        check("sb_read", rd_word(p_rvalid, b_rvalid, rd_data),
              (rd_q.size() != 0) ? rd_q.pop_front() : 32'hFFFFFFFF);
    end
  end

  task automatic b_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    b_we = 1'b1; b_waddr = a; b_wdata = d;
    ref_mem[a] = d;
    wr_q.push_back(wr_word(a, d));
    tick();
  endtask

  initial begin
    logic exp_b_second;
    int n;
    res = 1'b1; clr_req = 0; b_req = 0; b_we = 0; b_re = 0; b_waddr = '0; b_wdata = '0;
    b_raddr = '0; p_req = 0; p_re = 0; p_raddr = '0;
    tick(); tick();
    check("rst_b_gnt", 32'(b_gnt), 0);
    check("rst_p_gnt", 32'(p_gnt), 0);
    check("rst_clr_busy", 32'(clr_busy), 0);
    check("rst_clr_done", 32'(clr_done), 0);
    check("rst_sram_ctl", {28'b0, wEnable, rEnable, writeFlag, readFlag}, 32'b0100);
    check("rst_waddr", 32'(waddr), 0);
    check("rst_newcounts", 32'(newCounts), 0);
    res = 1'b0;
    tick();

    // full clear sweep, with a stray clr_req in the middle that must be ignored
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      check("clr_busy", 32'(clr_busy), 1);
      check("clr_waddr", 32'(waddr), 32'(i));
      check("clr_wen", {30'b0, wEnable, writeFlag}, 32'b11);
      clr_req = (i == 300);
      tick();
    end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    check("clr_done_pulse", 32'(clr_done), 1);
    check("clr_busy_end", 32'(clr_busy), 0);
    tick();
    check("clr_done_1cyc", 32'(clr_done), 0);
    check("clr_no_restart", 32'(clr_busy), 0);

    // simultaneous requests: builder wins, writes then pipelined reads
    b_req = 1'b1; p_req = 1'b1;
    tick();
    check("tie_b_gnt", 32'(b_gnt), 1);
    check("tie_p_gnt", 32'(p_gnt), 0);
    b_write(10'd5, 12'd7);
    check("wr_waddr", 32'(waddr), 5);
    check("wr_newcounts", 32'(newCounts), 7);
    check("wr_ctl", {30'b0, wEnable, writeFlag}, 32'b11);
    b_write(10'd6, 12'($urandom_range(1, 4095)));
    b_write(10'd9, 12'($urandom_range(1, 4095)));
    b_we = 1'b0;
    b_re = 1'b1; b_raddr = 10'd5; rd_q.push_back(rd_word(1'b0, 1'b1, ref_mem[5]));
    tick();
    b_raddr = 10'd9; rd_q.push_back(rd_word(1'b0, 1'b1, ref_mem[9]));
    tick();
    b_re = 1'b0;
    tick(); tick(); tick();

    // builder releases: one idle cycle, then the waiting peak finder
    b_req = 1'b0;
    tick();
    check("rel_gnts", {30'b0, b_gnt, p_gnt}, 0);
    check("rel_sram_idle", {28'b0, wEnable, rEnable, writeFlag, readFlag}, 32'b0100);
    b_we = 1'b1; b_waddr = 10'd10; b_wdata = 12'd1;
    tick();
    check("p_gnt_after_drop", {30'b0, b_gnt, p_gnt}, 32'b01);
    p_re = 1'b1; p_raddr = 10'd6; rd_q.push_back(rd_word(1'b1, 1'b0, ref_mem[6]));
    tick();
    p_re = 1'b0;
    check("p_read_ctl", {30'b0, rEnable, readFlag}, 32'b01);
    check("nonowner_no_write", 32'(wEnable), 0);
    tick();
    check("p_rvalid", {30'b0, p_rvalid, b_rvalid}, 32'b10);
    b_we = 1'b0; p_req = 1'b0;
    tick(); tick();

    // clear requested while the builder owns the port stays pending
    b_req = 1'b1;
    tick();
    check("pend_b_gnt", 32'(b_gnt), 1);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    check("pend_no_effect", {30'b0, clr_busy, b_gnt}, 32'b01);
    tick(); tick();
    check("pend_still_held", {30'b0, clr_busy, b_gnt}, 32'b01);
    p_req = 1'b1; b_req = 1'b0;
    tick();
    check("pend_idle", {30'b0, clr_busy, b_gnt}, 0);
    tick();
    check("pend_clear_first", {30'b0, clr_busy, p_gnt}, 32'b10);
    check("pend_clear_addr0", 32'(waddr), 0);
    for (int i = 0; i < 500; i++) tick();
    check("abort_at_500", 32'(waddr), 500);
    res = 1'b1; p_req = 1'b0;
    tick();
    check("abort_busy", {30'b0, clr_busy, clr_done}, 0);
    check("abort_waddr", 32'(waddr), 0);
    res = 1'b0;
    tick();
    check("abort_no_done", {30'b0, clr_busy, clr_done}, 0);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    check("restart_addr0", {15'b0, clr_busy, 6'b0, waddr}, {15'b0, 1'b1, 16'b0});
    n = 0;
    while (!clr_done && n < 1100) begin
      tick();
      n++;
    end
    check("restart_done", 32'(clr_done), 1);
    check("restart_len", 32'(n), 32'(DEPTH));
    tick();

    // reset during a grant discards the in-flight read
    b_req = 1'b1;
    tick();
    b_re = 1'b1; b_raddr = 10'd5;
    tick();
    check("inflight_ren", 32'(rEnable), 0);
    res = 1'b1; b_re = 1'b0; b_req = 1'b0;
    tick();
    check("rst_grant_drop", {29'b0, b_gnt, b_rvalid, rEnable}, 32'b001);
    res = 1'b0;
    tick();
    check("rst_rvalid_gone", 32'(b_rvalid), 0);

    // repeated ties: builder first, then round-robin alternation when enabled
    b_req = 1'b1; p_req = 1'b1;
    tick();
    check("tie1", {30'b0, b_gnt, p_gnt}, 32'b10);
    b_req = 1'b0; p_req = 1'b0;
    tick();
    b_req = 1'b1; p_req = 1'b1;
    tick();
`ifdef SRAM_ARB_RR_EN
    exp_b_second = 1'b0;
`else
    exp_b_second = 1'b1;
`endif
    check("tie2", {30'b0, b_gnt, p_gnt}, {30'b0, exp_b_second, ~exp_b_second});
    b_req = 1'b0; p_req = 1'b0;
    tick(); tick(); tick();
    check("sb_wr_empty", 32'(wr_q.size()), 0);
    check("sb_rd_empty", 32'(rd_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
